// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: target side of the SRAM-like data bus, backed by a local
// word-addressed RAM and an in-order outstanding-request queue with a fixed response latency.
// Ports: clk/reset (sync, active-low); dcache_req/wr/wstrb/size/addr/wdata in;
//        dcache_addr_ok (combinational accept), dcache_data_ok/rdata (in-order responses) out.
// Optional: define DBUS_RESP_RANDOM_STALL_EN to let a 16-bit LFSR randomly withhold addr_ok.
module dbus_sram_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DEPTH      = 4,
  parameter int          LATENCY    = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dcache_req,
  input  logic        dcache_wr,
  input  logic [3:0]  dcache_wstrb,
  input  logic [2:0]  dcache_size,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  output logic        dcache_addr_ok,
  output logic        dcache_data_ok,
  output logic [31:0] dcache_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LATENCY - 1);

  logic [31:0]           mem     [2**ADDR_WIDTH];
  logic                  q_wr    [DEPTH];
  logic [31:0]           q_rdata [DEPTH];
  logic [TW-1:0]         q_timer [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW:0]           count;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  space;
  logic                  accept;
  logic                  pop;

  assign widx  = dcache_addr[ADDR_WIDTH+1:2];
  // Registered occupancy only: a pop this cycle frees its slot next cycle.
  assign space = (count < (PW+1)'(DEPTH));

`ifdef DBUS_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign dcache_addr_ok = space && !lfsr[0];
`else
  assign dcache_addr_ok = space;
`endif

  // Size is informational and upper/byte-offset address bits alias away.
  logic unused;
  assign unused = ^{dcache_size, dcache_addr[31:ADDR_WIDTH+2], dcache_addr[1:0], LFSR_SEED};

  assign accept         = reset && dcache_req && dcache_addr_ok;
  assign dcache_data_ok = (count != '0) && (q_timer[rptr] == '0);
  assign pop            = dcache_data_ok;
  assign dcache_rdata   = (pop && !q_wr[rptr]) ? q_rdata[rptr] : 32'h0;

  // RAM is never reset; byte-masked write at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && dcache_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (dcache_wstrb[i]) mem[widx][8*i +: 8] <= dcache_wdata[8*i +: 8];
      end
    end
  end

  // Read data is captured at accept, so later writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_wr[wptr]    <= dcache_wr;
      q_rdata[wptr] <= dcache_wr ? 32'h0 : mem[widx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q_timer[i] <= '0;
    end else begin
      // All timers run down independently; an expired younger entry waits for head.
      for (int i = 0; i < DEPTH; i++) begin
        if (q_timer[i] != '0) q_timer[i] <= q_timer[i] - TW'(1);
      end
      if (accept) begin
        q_timer[wptr] <= TIMER_LOAD;
        wptr          <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Target-side model of the core's SRAM-like data bus: the responder to the execute stage's dcache_req / addr_ok / data_ok initiator.
- Backs the bus with a local word-addressed RAM, an in-order outstanding-request queue and a fixed response latency.
- Used as the uncached/test data memory behind the core and as the reference responder in execute-stage benches.

Parameters:
- ADDR_WIDTH, 10: log2 of RAM depth in 32-bit words.
- DEPTH, 4: maximum outstanding requests; power of 2, at least 2.
- LATENCY, 2: cycles from accept edge to data_ok; at least 1.
- LFSR_SEED, 16'hACE1: seed for the optional stall LFSR; must be non-zero.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- dcache_req  in  1  request valid.
- dcache_wr  in  1  1 = write, 0 = read.
- dcache_wstrb  in  4  write byte enables; ignored on reads.
- dcache_size  in  3  access size, 0/1/2 = byte/half/word; informational only.
- dcache_addr  in  32  byte address.
- dcache_wdata  in  32  write data.
- dcache_addr_ok  out  1  request accepted this cycle when dcache_req is also 1.
- dcache_data_ok  out  1  one response completes this cycle.
- dcache_rdata  out  32  read data, valid with data_ok.

Behaviour:
- Accept: dcache_req && dcache_addr_ok. addr_ok is combinational: (count < DEPTH). A pop in the same cycle does not free a slot for that cycle's request.
- Word index is dcache_addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses alias.
- Write on accept: RAM bytes with wstrb[i]=1 are updated at the accept edge with wdata[8i+7:8i]. wstrb=0 is legal: no change, still acknowledged.
- Read on accept: the RAM word is sampled at the accept edge, after any earlier accepted write, and stored in the queue entry. This gives program-order read-after-write.
- Queue entry fields: wr, rdata, timer. Timer is loaded with LATENCY-1 at push and decrements every cycle while non-zero (all entries).
- data_ok = queue non-empty && head.timer==0. Pop on data_ok; at most one per cycle; responses strictly in accept order.
- A younger entry whose timer expires waits behind the head and completes on the first cycle it is head.
- rdata = head.rdata when data_ok && !head.wr; otherwise 32'h0.
- Latency: with no head-of-line blocking, data_ok is asserted exactly LATENCY cycles after the accept edge. LATENCY=1 means the cycle immediately after accept.
- Throughput: one accept and one response per cycle, sustained.
- count and pointers:
  - Simultaneous push and pop leaves count unchanged.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Reset (reset==0 at an edge):
  - Queue emptied, pointers and count cleared; addr_ok=1 after release unless the optional stall suppresses it.
  - data_ok=0, rdata=0.
  - In-flight requests are discarded without a response.
  - RAM contents are NOT reset. Writes accepted before reset remain.
- No flush input. The initiator must drain or reset.

Optional Feature:
- DBUS_RESP_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) loaded with LFSR_SEED on reset, stepping every cycle.
  - addr_ok = (count < DEPTH) && !lfsr[0].
  - Response timing is unchanged.
- Undefined: no LFSR; addr_ok depends on occupancy only.

Test Plan:
- Write 0xDEADBEEF to 0x100, wstrb=4'hF, then read 0x100 -> read data_ok exactly LATENCY cycles after its accept, rdata=0xDEADBEEF.
- After the above, write 0x000000AA to 0x100 with wstrb=4'h1, then read -> rdata=0xDEADBEAA. A write with wstrb=0 still produces data_ok and changes nothing.
- Hold req=1 for DEPTH+2 back-to-back reads with LATENCY=8 -> addr_ok drops after DEPTH accepts and reasserts the cycle after the first data_ok. Data returns in order with no loss.
- Read 0x100 then read 0x100+(4<<ADDR_WIDTH) -> identical rdata (aliasing).
- Issue 3 requests, assert reset==0 for one cycle before any data_ok -> no data_ok afterwards, count=0, addr_ok=1. RAM still holds earlier writes.
- Run 20 alternating write/read pairs to distinct addresses, exercising pointer wrap -> every read returns its paired write data, and data_ok count equals accept count.
